// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot transmitter states and parity modes.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_e;

  // Parity bit to put on the line, given the XOR of the data bits.
  function automatic logic parity_bit(input int mode, input logic data_xor);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read and registered status.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_nxt;
  logic             do_wr, do_rd;

  // Requests are gated here so a full/empty buffer is never corrupted.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)      count_nxt = count + 1'b1;
    else if (!do_wr && do_rd) count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally at DEPTH (power of two); flags track count_nxt.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: start, LSB-first data, optional parity, stop bits.
module uart_tx_framed import uart_pkg::*; #(
  parameter int CLK_CYCLES_PER_BIT = 219,
  parameter int DATA_BITS          = 8,
  parameter int PARITY             = 0,
  parameter int STOP_BITS          = 1,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        in_ready,
  output logic                        tx_data,
  output logic                        tx_active,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(CLK_CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLK_CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e            state, state_nxt;
  logic [CW-1:0]        cyc, cyc_nxt;
  logic [BW-1:0]        bitn, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic                 par, par_nxt;
  logic                 bit_end, pop, frame_end, line, done_q;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full, fifo_empty;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Inverted flop output; the write is gated by the same flag inside the FIFO.
  assign in_ready = ~fifo_full;
  assign bit_end  = (cyc == CYC_LAST);

  // Next state, bit timing and line level; pops happen on the edge a frame begins.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    bit_nxt   = bitn;
    sh_nxt    = shreg;
    par_nxt   = par;
    pop       = 1'b0;
    frame_end = 1'b0;
    line      = 1'b1;
    if (state != ST_IDLE) cyc_nxt = bit_end ? '0 : cyc + 1'b1;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (bit_end) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        line = shreg[0];
        if (bit_end) begin
          sh_nxt = shreg >> 1;
          if (bitn == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_nxt = bitn + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        line = par;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bitn == STOP_LAST) begin
            frame_end = 1'b1;
            bit_nxt   = '0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = ST_START;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            bit_nxt = bitn + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (pop) begin
      sh_nxt  = fifo_rd_data;
      par_nxt = parity_bit(PARITY, ^fifo_rd_data);
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cyc   <= '0;
      bitn  <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
      bitn  <= bit_nxt;
      shreg <= sh_nxt;
      par   <= par_nxt;
    end
  end

  // Registered outputs; tx_done trails frame_end by two edges so it lands
  // the cycle after the last stop-bit cycle seen on tx_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data   <= 1'b1;
      tx_active <= 1'b0;
      done_q    <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_data   <= line;
      tx_active <= (state != ST_IDLE);
      done_q    <= frame_end;
      tx_done   <= done_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench: four frame formats against a frame-schedule model.
module tb_uart_tx_framed;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NI    = 4;
  // Instances: 8N1, 8E1, 8O1, 7N2
  localparam int DB[NI] = '{8, 8, 8, 7};
  localparam int PM[NI] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
  localparam int SB[NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       vld  [NI];
  logic [7:0] din  [NI];
  logic       rdy  [NI];
  logic       txd  [NI];
  logic       act  [NI];
  logic       done [NI];
  logic [2:0] fcnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_framed #(
      .CLK_CYCLES_PER_BIT(CPB), .DATA_BITS(DB[g]), .PARITY(PM[g]),
      .STOP_BITS(SB[g]), .FIFO_DEPTH(DEPTH)
    ) dut (
      .clk(clk), .reset(rst), .in_valid(vld[g]), .in_data(din[g][DB[g]-1:0]),
      .in_ready(rdy[g]), .tx_data(txd[g]), .tx_active(act[g]),
      .tx_done(done[g]), .fifo_count(fcnt[g])
    );
  end

  int e, ntests, nfail;

  // Model: pending words, the frame currently scheduled on the line, and
  // the edges at which tx_done is due.
  int   m_cnt [NI];
  int   m_q   [NI][DEPTH];
  int   m_s   [NI];
  int   m_word[NI];
  int   m_free[NI];
  int   m_da  [NI];
  int   m_db  [NI];
  logic m_acc [NI];
  logic x_tx [NI], x_act [NI], x_done [NI], x_rdy [NI];
  int   x_cnt[NI];

  function automatic int nbits(int i);
    return 1 + DB[i] + ((PM[i] != PARITY_NONE) ? 1 : 0) + SB[i];
  endfunction

  // Bit k of a frame: 0 start, data LSB first, parity, stop bits.
  function automatic logic frame_bit(int i, int w, int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= DB[i]) return ((w >> (k - 1)) & 1) != 0;
    if (PM[i] != PARITY_NONE && k == DB[i] + 1) begin
      ones = 0;
      for (int j = 0; j < DB[i]; j++) ones += (w >> j) & 1;
      return (PM[i] == PARITY_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0);
    end
    return 1'b1;
  endfunction

  task automatic model_edge(int i);
    int  len, w;
    logic pop, push;
    if (rst) begin
      m_cnt[i] = 0; m_s[i] = -1000; m_free[i] = 0; m_da[i] = -1; m_db[i] = -1;
      m_acc[i] = 1'b0;
      x_tx[i] = 1'b1; x_act[i] = 1'b0; x_done[i] = 1'b0; x_cnt[i] = 0; x_rdy[i] = 1'b1;
      return;
    end
    len = nbits(i) * CPB;
    x_tx[i]  = 1'b1;
    x_act[i] = 1'b0;
    if (e >= m_s[i] && e < m_s[i] + len) begin
      x_act[i] = 1'b1;
      x_tx[i]  = frame_bit(i, m_word[i], (e - m_s[i]) / CPB);
    end
    x_done[i] = (e == m_da[i]) || (e == m_db[i]);
    pop  = (m_cnt[i] > 0) && (e >= m_free[i]);
    push = vld[i] && (m_cnt[i] < DEPTH);
    m_acc[i] = push;
    if (pop) begin
      w = m_q[i][0];
      for (int j = 0; j < DEPTH - 1; j++) m_q[i][j] = m_q[i][j+1];
      m_cnt[i]--;
      m_word[i] = w;
      m_s[i]    = e + 1;
      m_free[i] = e + len;
      m_db[i]   = m_da[i];
      m_da[i]   = e + 1 + len;
    end
    if (push) begin
      m_q[i][m_cnt[i]] = int'(din[i]) & ((1 << DB[i]) - 1);
      m_cnt[i]++;
    end
    x_cnt[i] = m_cnt[i];
    x_rdy[i] = (m_cnt[i] < DEPTH);
  endtask

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] edge %0d: got %0h expected %0h", tag, i, e, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, advance the model, compare.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    for (int i = 0; i < NI; i++) begin
      model_edge(i);
      chk("tx_data",    i, 32'(txd[i]),  32'(x_tx[i]));
      chk("tx_active",  i, 32'(act[i]),  32'(x_act[i]));
      chk("tx_done",    i, 32'(done[i]), 32'(x_done[i]));
      chk("fifo_count", i, 32'(fcnt[i]), 32'(x_cnt[i]));
      chk("in_ready",   i, 32'(rdy[i]),  32'(x_rdy[i]));
    end
  endtask

  initial begin
    int nd, ac, nacc, cyc, p, rate;
    ntests = 0; nfail = 0; e = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin vld[i] = 1'b0; din[i] = 8'h00; end

    // Reset, with a write offered that must be ignored
    vld[0] = 1'b1; din[0] = 8'hA5;
    tick(); tick();
    vld[0] = 1'b0; rst = 1'b0;
    tick(); tick();

    // 8N1 0x55; 8E1 and 8O1 0x07, all pushed on the same edge
    vld[0] = 1'b1; din[0] = 8'h55;
    vld[1] = 1'b1; din[1] = 8'h07;
    vld[2] = 1'b1; din[2] = 8'h07;
    tick();
    for (int i = 0; i < NI; i++) vld[i] = 1'b0;
    for (int k = 1; k <= 47; k++) begin
      tick();
      if (k == 1) chk("n1_pre_start", 0, 32'(txd[0]), 32'd1);
      if (k >= 2 && k <= 5) chk("n1_start", 0, 32'(txd[0]), 32'd0);
      if (k >= 6 && k <= 37) chk("n1_data", 0, 32'(txd[0]), 32'(((k - 6) / 4) % 2 == 0));
      if (k >= 38 && k <= 41) chk("n1_stop", 0, 32'(txd[0]), 32'd1);
      chk("n1_done", 0, 32'(done[0]), 32'(k == 42));
      if (k == 38) begin
        chk("e1_parity", 1, 32'(txd[1]), 32'd1);
        chk("o1_parity", 2, 32'(txd[2]), 32'd0);
      end
      if (k == 45) chk("e1_active_end", 1, 32'(act[1]), 32'd1);
      if (k == 46) begin
        chk("e1_active_off", 1, 32'(act[1]), 32'd0);
        chk("e1_done", 1, 32'(done[1]), 32'd1);
      end
    end

    // 7N2 back-to-back: 0x7F then 0x00
    vld[3] = 1'b1; din[3] = 8'h7F; tick();
    din[3] = 8'h00; tick();
    vld[3] = 1'b0;
    nd = 0; ac = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (done[3]) nd++;
      if (act[3]) ac++;
    end
    chk("n2_done_pulses", 3, 32'(nd), 32'd2);
    chk("n2_active_cycles", 3, 32'(ac), 32'd80);

    // Six words offered continuously; data only changes once accepted
    nacc = 0; cyc = 0;
    vld[0] = 1'b1; din[0] = 8'($urandom);
    while (nacc < 6 && cyc < 400) begin
      tick(); cyc++;
      if (m_acc[0]) begin
        nacc++;
        din[0] = 8'($urandom);
        if (nacc == 5) begin
          chk("five_consecutive", 0, 32'(cyc), 32'd5);
          chk("full_count", 0, 32'(fcnt[0]), 32'd4);
          chk("full_ready", 0, 32'(rdy[0]), 32'd0);
        end
      end
    end
    vld[0] = 1'b0;
    chk("six_accepted", 0, 32'(nacc), 32'd6);
    repeat (260) tick();

    // Reset during data bit 3 with two words still buffered
    vld[0] = 1'b1; din[0] = 8'($urandom); tick(); p = e;
    din[0] = 8'($urandom); tick();
    din[0] = 8'($urandom); tick();
    vld[0] = 1'b0;
    while (e < p + 18) tick();
    chk("pre_reset_count", 0, 32'(fcnt[0]), 32'd2);
    rst = 1'b1; vld[0] = 1'b1; din[0] = 8'h3C;
    tick();
    rst = 1'b0; vld[0] = 1'b0;
    chk("abort_line", 0, 32'(txd[0]), 32'd1);
    chk("abort_count", 0, 32'(fcnt[0]), 32'd0);
    nd = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done[0]) nd++;
    end
    chk("abort_no_done", 0, 32'(nd), 32'd0);
    vld[0] = 1'b1; din[0] = 8'hC3; tick();
    vld[0] = 1'b0;
    repeat (50) tick();

    // Random traffic on all formats: sparse, then saturating
    for (int c = 0; c < 2000; c++) begin
      rate = (c < 1000) ? 3 : 30;
      for (int i = 0; i < NI; i++) begin
        vld[i] = ($urandom_range(0, 99) < rate);
        din[i] = 8'($urandom);
      end
      tick();
    end
    for (int i = 0; i < NI; i++) vld[i] = 1'b0;
    repeat (300) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 Parameter CLK_CYCLES_PER_BIT, default 219, clock cycles per bit (25.2 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16, transmit buffer entries; power of two, 2..256.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  producer offers in_data this cycle.
REQ-009 in_data  input  DATA_BITS  byte/word to transmit, LSB first.
REQ-010 in_ready  output  1  buffer can accept; equals not-full.
REQ-011 tx_data  output  1  serial line, idle high.
REQ-012 tx_active  output  1  high while any frame bit is on the line.
REQ-013 tx_done  output  1  one-cycle pulse per completed frame.
REQ-014 fifo_count  output  clog2(FIFO_DEPTH)+1  current buffered entries.

Function
REQ-015 Word accepted on any edge with in_valid and in_ready both high; in_data ignored otherwise.
REQ-016 Frame order: start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY!=0, STOP_BITS stop bits (1); each bit held exactly CLK_CYCLES_PER_BIT cycles.
REQ-017 Parity: even mode = XOR of data bits; odd mode = inverted XOR.
REQ-018 States: IDLE, START, DATA, PARITY, STOP; one-hot encoded; PARITY skipped when PARITY=0.
REQ-019 IDLE -> START on edge where buffer non-empty (pop same edge); START -> DATA, DATA -> PARITY/STOP after last data bit, STOP -> START if buffer non-empty at final stop-bit edge else IDLE.
REQ-020 Latency: word accepted into empty buffer, idle transmitter, at edge N -> tx_data low from edge N+2.
REQ-021 Back-to-back frames: next start bit immediately follows last stop bit, zero idle cycles.
REQ-022 tx_done high exactly one cycle, the cycle after the final stop-bit period ends, including when next frame starts.
REQ-023 tx_active high from first start-bit cycle through last stop-bit cycle; stays high across back-to-back frames.
REQ-024 Simultaneous push and pop: fifo_count unchanged, both words handled correctly.
REQ-025 Full: in_ready low, no write, no overwrite; empty: no pop, tx_data high.
REQ-026 Read/write pointers wrap modulo FIFO_DEPTH; fifo_count saturates at no value beyond FIFO_DEPTH.
REQ-027 Bit counter and cycle counter widths derived from DATA_BITS and CLK_CYCLES_PER_BIT via clog2.

Reset
REQ-028 reset high at edge: state IDLE, tx_data 1, tx_active 0, tx_done 0, fifo_count 0, in_ready 1, all counters 0.
REQ-029 Reset mid-frame aborts frame: tx_data 1 next edge, buffer flushed, no tx_done pulse.
REQ-030 in_valid ignored during reset cycle.

Structure
REQ-031 Shared package uart_pkg holds state encodings and parity-mode constants (PARITY_NONE, PARITY_ODD, PARITY_EVEN).
REQ-032 Buffer implemented as sub-module uart_tx_fifo (synchronous FIFO, parameters WIDTH, DEPTH, outputs count/full/empty).
REQ-033 All outputs registered.

Verification (CLK_CYCLES_PER_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-034 8N1, push 0x55 at edge 0 -> tx_data low edges 2-5, then 1,0,1,0,1,0,1,0 each 4 cycles, high edges 38-41, tx_done pulse edge 42.
REQ-035 8E1 push 0x07 -> parity bit 1; 8O1 push 0x07 -> parity bit 0; frame length 44 cycles.
REQ-036 7N2 push 0x7F then 0x00 consecutive -> two stop-bit periods (8 cycles high), second start bit immediately after, tx_active never drops, two tx_done pulses.
REQ-037 Push 6 words on consecutive edges -> 5 accepted, in_ready low after fifth, sixth held until first frame completes; fifo_count peaks at 4.
REQ-038 Assert reset during DATA bit 3 of a frame with 2 words buffered -> tx_data 1, fifo_count 0, no tx_done, next pushed word transmits normally.
